imm_decode_unit: RTL and testbench
==================================

// Module: imm_decode_unit
// PURPOSE
//   Registered successor to the combinational ImmSrc decoder. Decodes the opcode of a
//   fetched instruction, selects the immediate format, builds the sign-extended
//   XLEN-wide immediate and flags illegal opcodes. Output is a one-entry valid/ready
//   stage. Sits between the instruction register and the multicycle control/ALU datapath.
// PARAMETERS
//   XLEN   32  immediate/datapath width; legal values are 32 and 64
//   CNT_W  8   width of the saturating illegal-instruction counter
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high reset
//   flush          in   1      drop held result and any same-cycle transfer
//   in_valid       in   1      instr is valid
//   in_ready       out  1      unit can accept instr this cycle
//   instr          in   32     raw RV32 instruction word
//   out_valid      out  1      registered decode result is valid
//   out_ready      in   1      consumer accepts the result
//   imm_src        out  3      000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (macro only)
//   imm_ext        out  XLEN   extended immediate
//   illegal        out  1      opcode not recognised
//   illegal_count  out  CNT_W  saturating count of accepted illegal instructions
// BEHAVIOUR
//   - Reset values: out_valid=0, imm_src=000, imm_ext=0, illegal=0, illegal_count=0.
//   - Opcode map: LW 0000011->I, SW 0100011->S, I-ALU 0010011->I, R 0110011->I,
//     BRANCH 1100011->B, JAL 1101111->J, JALR 1100111->I, LUI 0110111 and AUIPC 0010111->U.
//     Any other opcode: illegal=1, imm_src=000, imm_ext=0. No latches; every path is assigned.
//   - Immediates sign-extend from instr[31] to XLEN:
//     I {instr[31:20]}; S {instr[31:25],instr[11:7]};
//     B {instr[31],instr[7],instr[30:25],instr[11:8],0};
//     J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U {instr[31:12],12'b0}.
//   - Handshake: in_ready = !flush && (!out_valid || out_ready), combinational.
//     Accept = in_valid && in_ready. Outputs load on the edge after Accept (latency 1).
//     With out_valid=1 && out_ready=1 and no Accept, out_valid clears next cycle.
//     Simultaneous drain and Accept gives back-to-back throughput of 1/cycle.
//   - While out_valid=1 && out_ready=0: imm_src, imm_ext, illegal hold stable.
//   - flush: out_valid=0 next cycle; the same-cycle input is not accepted; data regs
//     keep their old values. reset has priority over flush.
//   - illegal_count increments by 1 on Accept of an illegal instruction.
//     It saturates at 2^CNT_W-1 and never wraps. Only reset clears it; flush does not.
//   - Reset asserted mid-transfer discards the held result; in_ready is 1 the cycle after.
// CONFIGURATION
//   IMM_DECODE_ZICSR_EN defined: SYSTEM opcode 1110011 is legal.
//     If funct3[2]=1 (CSR-immediate forms): imm_src=101, imm_ext = zero-extended instr[19:15].
//     Otherwise: imm_src=000, I-format immediate (CSR address).
//   IMM_DECODE_ZICSR_EN undefined: 1110011 is illegal like any unknown opcode;
//     code 101 is never produced.
// TESTING
//   1 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm_src=000,
//     imm_ext=0xFFFFFFFF, illegal=0.
//   2 0x00112623 (sw) then 0xFE000EE3 (beq -4) back to back -> imm_src=001, imm_ext=0x0000000C;
//     then imm_src=010, imm_ext=0xFFFFFFFC on consecutive cycles.
//   3 0x123450B7 (lui) with out_ready=0 for 3 cycles -> imm_src=100, imm_ext=0x12345000
//     held stable, in_ready=0; one cycle after out_ready=1, out_valid=0.
//   4 0x0000007F x300 accepted, CNT_W=8 -> illegal=1, imm_ext=0, illegal_count stops at 255.
//   5 flush pulsed with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not
//     accepted, illegal_count unchanged; reset mid-hold -> all outputs at reset values.
//   6 0x3401D073 (csrrwi mscratch,3) -> with IMM_DECODE_ZICSR_EN: imm_src=101, imm_ext=3;
//     without it: illegal=1, imm_ext=0.

Source files
------------

// File: rtl/imm_decode_unit.sv
// Registered immediate decoder with a one-entry valid/ready output stage and a
// saturating illegal-opcode counter. Define IMM_DECODE_ZICSR_EN to accept SYSTEM (CSR) opcodes.
module imm_decode_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       imm_src,
    output logic [XLEN-1:0]  imm_ext,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;
    localparam logic [2:0] SRC_Z = 3'b101;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; ready never depends on valid, and a producer holds valid/data until taken.

    logic             out_valid_q, out_valid_d;
    logic [2:0]       imm_src_q, imm_src_d;
    logic [XLEN-1:0]  imm_ext_q, imm_ext_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    logic             accept;
    logic [2:0]       dec_src;
    logic [31:0]      dec_imm32;
    logic             dec_illegal;

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // All formats are assembled at 32 bits (sign already replicated) and widened once.
    always_comb begin
        dec_src     = SRC_I;
        dec_imm32   = '0;
        dec_illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                dec_src   = SRC_I;
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_REG: begin
                dec_src   = SRC_I;
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                dec_src   = SRC_S;
                dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                dec_src   = SRC_B;
                dec_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_src   = SRC_J;
                dec_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_src   = SRC_U;
                dec_imm32 = {instr[31:12], 12'b0};
            end
`ifdef IMM_DECODE_ZICSR_EN
            OP_SYSTEM: begin
                if (instr[14]) begin
                    dec_src   = SRC_Z;
                    dec_imm32 = {27'b0, instr[19:15]};
                end else begin
                    dec_src   = SRC_I;
                    dec_imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
`endif
            default: begin
                dec_src     = SRC_I;
                dec_imm32   = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Flush wins over everything but reset; data registers only move on accept.
    always_comb begin
        out_valid_d     = out_valid_q;
        imm_src_d       = imm_src_q;
        imm_ext_d       = imm_ext_q;
        illegal_d       = illegal_q;
        illegal_count_d = illegal_count_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            imm_src_d   = dec_src;
            imm_ext_d   = XLEN'($signed(dec_imm32));
            illegal_d   = dec_illegal;
            if (dec_illegal && (illegal_count_q != {CNT_W{1'b1}})) begin
                illegal_count_d = illegal_count_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q     <= 1'b0;
            imm_src_q       <= SRC_I;
            imm_ext_q       <= '0;
            illegal_q       <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            imm_src_q       <= imm_src_d;
            imm_ext_q       <= imm_ext_d;
            illegal_q       <= illegal_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign imm_src       = imm_src_q;
    assign imm_ext       = imm_ext_q;
    assign illegal       = illegal_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_imm_decode_unit.sv
// Bench for imm_decode_unit: directed scenarios plus a randomized run against an
// arithmetic reference model and an expected-result queue.
module tb_imm_decode_unit;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int W       = XLEN + 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      instr = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       imm_src;
    logic [XLEN-1:0]  imm_ext;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    int checks = 0;
    int errors = 0;

    imm_decode_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_src(imm_src), .imm_ext(imm_ext), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // Reference: immediate value computed as a signed integer from field weights.
    // Returns {illegal, imm_src[2:0], imm_ext[XLEN-1:0]}.
    function automatic logic [W-1:0] ref_decode(input logic [31:0] ins);
        longint v;
        int     fmt;
        logic [W-1:0] r;
        v = 0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b0110011, 7'b1100111: fmt = 0;
            7'b0100011: fmt = 1;
            7'b1100011: fmt = 2;
            7'b1101111: fmt = 3;
            7'b0110111, 7'b0010111: fmt = 4;
`ifdef IMM_DECODE_ZICSR_EN
            7'b1110011: fmt = ins[14] ? 5 : 0;
`endif
            default: fmt = -1;
        endcase
        case (fmt)
            0: begin v = longint'(ins[31:20]); if (ins[31]) v = v - 4096; end
            1: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (ins[31]) v = v - 4096; end
            2: begin
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v = v - 4096;
            end
            3: begin
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v = v - (longint'(1) << 20);
            end
            4: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v = v - (longint'(1) << 32); end
            5: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        r[XLEN-1:0]  = v[XLEN-1:0];
        r[XLEN+2:XLEN] = (fmt < 0) ? 3'd0 : 3'(fmt);
        r[XLEN+3]    = (fmt < 0);
        return r;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (imm_src !== 3'b000) begin errors++; $display("FAIL reset_imm_src got %0b exp 000", imm_src); end
        checks++; if (imm_ext !== '0) begin errors++; $display("FAIL reset_imm_ext got %0h exp 0", imm_ext); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b exp 0", illegal); end
        checks++; if (illegal_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", illegal_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_addi;
        @(negedge clk);
        in_valid = 1'b1; instr = 32'hFFF00093; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got %0b exp 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b exp 1", out_valid); end
        checks++; if (imm_src !== 3'b000) begin errors++; $display("FAIL addi_src got %0b exp 000", imm_src); end
        checks++; if (imm_ext !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_ext got %0h exp ffffffff", imm_ext); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got %0b exp 0", illegal); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1; instr = 32'h00112623; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr = 32'hFE000EE3;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got %0b exp 1", out_valid); end
        checks++; if (imm_src !== 3'b001) begin errors++; $display("FAIL b2b_src_sw got %0b exp 001", imm_src); end
        checks++; if (imm_ext !== 32'h0000000C) begin errors++; $display("FAIL b2b_ext_sw got %0h exp c", imm_ext); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0b exp 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %0b exp 1", out_valid); end
        checks++; if (imm_src !== 3'b010) begin errors++; $display("FAIL b2b_src_beq got %0b exp 010", imm_src); end
        checks++; if (imm_ext !== 32'hFFFFFFFC) begin errors++; $display("FAIL b2b_ext_beq got %0h exp fffffffc", imm_ext); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        in_valid = 1'b1; instr = 32'h123450B7; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr = 32'h00112623;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b exp 1", i, out_valid); end
            checks++; if (imm_src !== 3'b100) begin errors++; $display("FAIL stall_src[%0d] got %0b exp 100", i, imm_src); end
            checks++; if (imm_ext !== 32'h12345000) begin errors++; $display("FAIL stall_ext[%0d] got %0h exp 12345000", i, imm_ext); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %0b exp 0", i, in_ready); end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %0b exp 0", out_valid); end
    endtask

    task automatic test_illegal_saturation;
        int exp_cnt;
        do_reset();
        in_valid = 1'b1; instr = 32'h0000007F; out_ready = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_cnt = (i > CNT_MAX) ? CNT_MAX : i;
            checks++;
            if (illegal_count !== CNT_W'(exp_cnt)) begin
                errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, illegal_count, exp_cnt);
            end
        end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL sat_illegal got %0b exp 1", illegal); end
        checks++; if (imm_ext !== '0) begin errors++; $display("FAIL sat_ext got %0h exp 0", imm_ext); end
        checks++; if (imm_src !== 3'b000) begin errors++; $display("FAIL sat_src got %0b exp 000", imm_src); end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush_reset;
        do_reset();
        in_valid = 1'b1; instr = 32'h0000007F; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (illegal_count !== CNT_W'(1)) begin errors++; $display("FAIL flush_pre_count got %0d exp 1", illegal_count); end
        flush = 1'b1; in_valid = 1'b1; instr = 32'h0000007F;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b exp 0", in_ready); end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
        checks++; if (illegal_count !== CNT_W'(1)) begin errors++; $display("FAIL flush_count got %0d exp 1", illegal_count); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL flush_data_hold got %0b exp 1", illegal); end
        in_valid = 1'b1; instr = 32'h123450B7; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %0b exp 1", out_valid); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b exp 0", out_valid); end
        checks++; if (imm_src !== 3'b000) begin errors++; $display("FAIL rst_mid_src got %0b exp 000", imm_src); end
        checks++; if (imm_ext !== '0) begin errors++; $display("FAIL rst_mid_ext got %0h exp 0", imm_ext); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_mid_illegal got %0b exp 0", illegal); end
        checks++; if (illegal_count !== '0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", illegal_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %0b exp 1", in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_csr;
        logic [31:0] vec [2];
        vec[0] = 32'h3401D073;
        vec[1] = 32'h34011073;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; instr = vec[i]; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
`ifdef IMM_DECODE_ZICSR_EN
            checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL csr_illegal[%0d] got %0b exp 0", i, illegal); end
            checks++; if (imm_src !== ((i == 0) ? 3'b101 : 3'b000)) begin errors++; $display("FAIL csr_src[%0d] got %0b", i, imm_src); end
            checks++; if (imm_ext !== ((i == 0) ? 32'd3 : 32'h340)) begin errors++; $display("FAIL csr_ext[%0d] got %0h", i, imm_ext); end
`else
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL csr_illegal[%0d] got %0b exp 1", i, illegal); end
            checks++; if (imm_src !== 3'b000) begin errors++; $display("FAIL csr_src[%0d] got %0b exp 000", i, imm_src); end
            checks++; if (imm_ext !== '0) begin errors++; $display("FAIL csr_ext[%0d] got %0h exp 0", i, imm_ext); end
`endif
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_e;
        logic [W-1:0] got;
        logic [6:0]   ops [10];
        logic [31:0]  r;
        logic [6:0]   op;
        logic         exp_rdy, exp_vld, acc;
        int           cnt;
        int           k;
        ops = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        do_reset();
        cnt = 0;
        repeat (600) begin
            r = $urandom();
            k = $urandom_range(0, 11);
            if (k < 10) op = ops[k]; else op = r[6:0];
            instr     = {r[31:7], op};
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            exp_vld = (exp_q.size() != 0);
            exp_rdy = !flush && (!exp_vld || out_ready);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready got %0b exp %0b", in_ready, exp_rdy); end
            checks++; if (out_valid !== exp_vld) begin errors++; $display("FAIL rnd_valid got %0b exp %0b", out_valid, exp_vld); end
            if (exp_vld) begin
                got = {illegal, imm_src, imm_ext};
                checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL rnd_data got %0h exp %0h", got, exp_q[0]); end
            end
            checks++; if (illegal_count !== CNT_W'(cnt)) begin errors++; $display("FAIL rnd_count got %0d exp %0d", illegal_count, cnt); end
            acc = in_valid && exp_rdy;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_vld && out_ready) void'(exp_q.pop_front());
                if (acc) begin
                    exp_e = ref_decode(instr);
                    exp_q.push_back(exp_e);
                    if (exp_e[W-1] && cnt < CNT_MAX) cnt++;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_illegal_saturation();
        test_flush_reset();
        test_csr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
